// File: rtl/gowin_tl_pkg.sv
// Shared types for the Gowin TL adapters: FSM state encoding, the internal beat
// record and the end-offset to per-DW valid mask helper.
package gowin_tl_pkg;

    localparam int unsigned MaxDw   = 8;
    localparam int unsigned MaxW    = 256;
    localparam int unsigned OffMaxW = 3;

    typedef enum logic [1:0] {
        StIdle,
        StPkt,
        StDrain
    } tx_state_e;

    // Sized for the widest configuration; narrower builds leave the top bits zero.
    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [MaxDw-1:0] valid;
        logic [MaxW-1:0]  data;
    } tl_beat_t;

    function automatic logic [MaxDw-1:0] end_offset_to_mask(input logic [OffMaxW-1:0] offset);
        logic [MaxDw-1:0] mask;
        for (int unsigned i = 0; i < MaxDw; i++) begin
            mask[i] = (i <= 32'(offset));
        end
        return mask;
    endfunction

endpackage

// File: rtl/gowin_tl_tx_adapter_if.sv
// Upstream RIFFA TX TLP stream (start/end/end-offset framing) feeding the TL TX adapter.
interface gowin_tl_tx_adapter_if #(
    parameter int unsigned C_PCI_DATA_WIDTH = 256
);
    localparam int unsigned NDW  = C_PCI_DATA_WIDTH / 32;
    localparam int unsigned OffW = $clog2(NDW);

    logic [C_PCI_DATA_WIDTH-1:0] TX_TLP;
    logic                        TX_TLP_VALID;
    logic                        TX_TLP_READY;
    logic                        TX_TLP_START_FLAG;
    logic                        TX_TLP_END_FLAG;
    logic [OffW-1:0]             TX_TLP_END_OFFSET;

    modport master (
        output TX_TLP,
        output TX_TLP_VALID,
        input  TX_TLP_READY,
        output TX_TLP_START_FLAG,
        output TX_TLP_END_FLAG,
        output TX_TLP_END_OFFSET
    );

    modport slave (
        input  TX_TLP,
        input  TX_TLP_VALID,
        output TX_TLP_READY,
        input  TX_TLP_START_FLAG,
        input  TX_TLP_END_FLAG,
        input  TX_TLP_END_OFFSET
    );

endinterface

// File: rtl/gowin_tl_skid_buf.sv
// Output register plus one skid entry: registered in_ready, output held while out_wait,
// flush empties both stages.
module gowin_tl_skid_buf
    import gowin_tl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     allow,
    input  logic     in_valid,
    input  tl_beat_t in_beat,
    output logic     in_ready,
    output tl_beat_t out_beat,
    input  logic     out_wait
);

    tl_beat_t out_q, out_d, skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     ready_q, ready_d;
    logic     out_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    // in_valid only arrives while ready_q is high, i.e. with the skid entry empty.
    always_comb begin
        out_free     = !out_valid_q || !out_wait;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_d        = '0;
            out_valid_d  = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_free) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_d       = '0;
                skid_valid_d = 1'b0;
            end
        end else if (in_valid) begin
            if (out_free) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end else if (out_free) begin
            out_d       = '0;
            out_valid_d = 1'b0;
        end
        ready_d = !skid_valid_d && allow;
    end

    assign in_ready = ready_q;
    assign out_beat = out_q;

endmodule

// File: rtl/gowin_tl_tx_adapter.sv
// RIFFA TX TLP stream to Gowin PCIE_Controller_Top TL TX port; framing FSM, DW mask, link flush.
// Optional GOWIN_TL_TX_ERR_EN adds the sticky ERR_O port (orphan, nested START, link flush).
module gowin_tl_tx_adapter
    import gowin_tl_pkg::*;
#(
    parameter int unsigned C_PCI_DATA_WIDTH = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             LINKUP_I,
    gowin_tl_tx_adapter_if.slave             tx,
    output logic                             PCIE_TL_TX_SOP_O,
    output logic                             PCIE_TL_TX_EOP_O,
    output logic [C_PCI_DATA_WIDTH-1:0]      PCIE_TL_TX_DATA_O,
    output logic [C_PCI_DATA_WIDTH/32-1:0]   PCIE_TL_TX_VALID_O,
    input  logic                             PCIE_TL_TX_WAIT_I
`ifdef GOWIN_TL_TX_ERR_EN
    ,
    output logic [2:0]                       ERR_O
`endif
);

    localparam int unsigned NDW = C_PCI_DATA_WIDTH / 32;

    tx_state_e        state_q, state_d;
    logic             link_q;
    logic             link_fall;
    logic             accept;
    logic             fwd;
    logic             sop;
    logic [MaxDw-1:0] end_mask;
    tl_beat_t         in_beat;
    tl_beat_t         out_beat;

    assign link_fall = link_q && !LINKUP_I;
    assign accept    = tx.TX_TLP_VALID && tx.TX_TLP_READY;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            link_q  <= LINKUP_I;
        end
    end

    // A TLP left open by a link drop is drained up to its END beat.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                StIdle:  if (tx.TX_TLP_START_FLAG && !tx.TX_TLP_END_FLAG) state_d = StPkt;
                StPkt:   if (tx.TX_TLP_END_FLAG) state_d = StIdle;
                StDrain: if (tx.TX_TLP_END_FLAG) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
        if (link_fall && state_d == StPkt) begin
            state_d = StDrain;
        end
    end

`ifdef GOWIN_TL_TX_ERR_EN
    logic [2:0] err_set, err_q;
`endif

    always_comb begin
        fwd = 1'b0;
        sop = 1'b0;
`ifdef GOWIN_TL_TX_ERR_EN
        err_set = {link_fall, 2'b00};
`endif
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    fwd = tx.TX_TLP_START_FLAG;
                    sop = tx.TX_TLP_START_FLAG;
`ifdef GOWIN_TL_TX_ERR_EN
                    err_set[0] = !tx.TX_TLP_START_FLAG;
`endif
                end
                StPkt: begin
                    fwd = 1'b1;
`ifdef GOWIN_TL_TX_ERR_EN
                    err_set[1] = tx.TX_TLP_START_FLAG;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef GOWIN_TL_TX_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    assign ERR_O = err_q;
`endif

    assign end_mask = end_offset_to_mask(OffMaxW'(tx.TX_TLP_END_OFFSET));

    always_comb begin
        in_beat                             = '0;
        in_beat.sop                         = sop;
        in_beat.eop                         = tx.TX_TLP_END_FLAG;
        in_beat.valid[NDW-1:0]              = tx.TX_TLP_END_FLAG ? end_mask[NDW-1:0] : '1;
        in_beat.data[C_PCI_DATA_WIDTH-1:0]  = tx.TX_TLP;
    end

    gowin_tl_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (link_fall),
        .allow    ((state_d == StDrain) || LINKUP_I),
        .in_valid (fwd),
        .in_beat  (in_beat),
        .in_ready (tx.TX_TLP_READY),
        .out_beat (out_beat),
        .out_wait (PCIE_TL_TX_WAIT_I)
    );

    assign PCIE_TL_TX_SOP_O   = out_beat.sop;
    assign PCIE_TL_TX_EOP_O   = out_beat.eop;
    assign PCIE_TL_TX_DATA_O  = out_beat.data[C_PCI_DATA_WIDTH-1:0];
    assign PCIE_TL_TX_VALID_O = out_beat.valid[NDW-1:0];

endmodule

// File: tb/tb_gowin_tl_tx_adapter.sv
// Randomized bench for gowin_tl_tx_adapter against a TLP-level scoreboard model;
// ERR_O is checked when GOWIN_TL_TX_ERR_EN is defined.
module tb_gowin_tl_tx_adapter;

    localparam int unsigned W   = 256;
    localparam int unsigned NDW = W / 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           LINKUP_I;
    logic           sop_o;
    logic           eop_o;
    logic [W-1:0]   data_o;
    logic [NDW-1:0] valid_o;
    logic           wait_i;
`ifdef GOWIN_TL_TX_ERR_EN
    logic [2:0]     err_o;
`endif

    gowin_tl_tx_adapter_if #(.C_PCI_DATA_WIDTH(W)) tx ();

    gowin_tl_tx_adapter #(.C_PCI_DATA_WIDTH(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .LINKUP_I           (LINKUP_I),
        .tx                 (tx),
        .PCIE_TL_TX_SOP_O   (sop_o),
        .PCIE_TL_TX_EOP_O   (eop_o),
        .PCIE_TL_TX_DATA_O  (data_o),
        .PCIE_TL_TX_VALID_O (valid_o),
        .PCIE_TL_TX_WAIT_I  (wait_i)
`ifdef GOWIN_TL_TX_ERR_EN
        ,
        .ERR_O              (err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           sop;
        logic           eop;
        logic [NDW-1:0] mask;
        logic [W-1:0]   data;
    } beat_t;

    beat_t      exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         in_pkt;
    bit         draining;
    bit         link_prev;
    bit         gen_open;
    logic [2:0] err_m;
    int         link_hold;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_pkt    = 1'b0;
        draining  = 1'b0;
        link_prev = 1'b0;
        gen_open  = 1'b0;
        err_m     = '0;
    endtask

    task automatic check_outputs();
        beat_t e;
        logic  exp_ready;
        exp_ready = draining || (link_prev && exp_q.size() < 2);
        check("ready", W'(tx.TX_TLP_READY), W'(exp_ready));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("sop", W'(sop_o), W'(e.sop));
            check("eop", W'(eop_o), W'(e.eop));
            check("dw_valid", W'(valid_o), W'(e.mask));
            check("data", data_o, e.data);
        end else begin
            check("idle_ctl", W'({sop_o, eop_o, valid_o}), '0);
            check("idle_data", data_o, '0);
        end
`ifdef GOWIN_TL_TX_ERR_EN
        check("err", W'(err_o), W'(err_m));
`endif
    endtask

    task automatic push_beat(input logic s);
        beat_t e;
        int    off;
        off    = int'(tx.TX_TLP_END_OFFSET);
        e.sop  = s;
        e.eop  = tx.TX_TLP_END_FLAG;
        e.mask = tx.TX_TLP_END_FLAG ? NDW'((32'd1 << (off + 1)) - 1) : '1;
        e.data = tx.TX_TLP;
        exp_q.push_back(e);
    endtask

    // Predicts the effect of the coming clock edge from the inputs and outputs now visible.
    task automatic step_model();
        bit take, acc, fall;
        take = (valid_o != '0) && !wait_i;
        acc  = tx.TX_TLP_VALID && tx.TX_TLP_READY;
        fall = link_prev && !LINKUP_I;
        if (take && exp_q.size() != 0) void'(exp_q.pop_front());
        if (fall) begin
            exp_q.delete();
            err_m[2] = 1'b1;
        end
        if (acc) begin
            if (draining) begin
                if (tx.TX_TLP_END_FLAG) draining = 1'b0;
            end else if (!in_pkt) begin
                if (tx.TX_TLP_START_FLAG) begin
                    if (!fall) push_beat(1'b1);
                    in_pkt = !tx.TX_TLP_END_FLAG;
                end else begin
                    err_m[0] = 1'b1;
                end
            end else begin
                if (tx.TX_TLP_START_FLAG) err_m[1] = 1'b1;
                if (!fall) push_beat(1'b0);
                if (tx.TX_TLP_END_FLAG) in_pkt = 1'b0;
            end
            gen_open = !tx.TX_TLP_END_FLAG;
        end
        if (fall && in_pkt) begin
            in_pkt   = 1'b0;
            draining = 1'b1;
        end
        link_prev = LINKUP_I;
    endtask

    task automatic run_cycles(input int n, input int wait_pct, input int drop_pm);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tx.TX_TLP_VALID      = $urandom_range(0, 99) < 70;
            tx.TX_TLP_START_FLAG = gen_open ? ($urandom_range(0, 99) < 5)
                                            : ($urandom_range(0, 99) < 90);
            tx.TX_TLP_END_FLAG   = $urandom_range(0, 99) < 35;
            tx.TX_TLP_END_OFFSET = 3'($urandom_range(0, 7));
            tx.TX_TLP            = {8{$urandom()}};
            wait_i               = $urandom_range(0, 99) < wait_pct;
            if (link_hold > 0) begin
                link_hold--;
            end else if (!LINKUP_I) begin
                LINKUP_I = 1'b1;
            end else if ($urandom_range(0, 999) < drop_pm) begin
                LINKUP_I  = 1'b0;
                link_hold = $urandom_range(0, 5);
            end
            #1;
            check_outputs();
            step_model();
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        LINKUP_I             = 1'b0;
        wait_i               = 1'b0;
        tx.TX_TLP            = '0;
        tx.TX_TLP_VALID      = 1'b0;
        tx.TX_TLP_START_FLAG = 1'b0;
        tx.TX_TLP_END_FLAG   = 1'b0;
        tx.TX_TLP_END_OFFSET = '0;
        link_hold            = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        rst_n    = 1'b1;
        LINKUP_I = 1'b1;
        check_outputs();
        step_model();

        run_cycles(1500, 30, 8);
        run_cycles(400, 0, 0);

        // Reach the middle of a TLP, then pulse reset for one cycle.
        for (int i = 0; i < 50 && !in_pkt; i++) run_cycles(1, 10, 0);
        @(negedge clk);
        rst_n           = 1'b0;
        tx.TX_TLP_VALID = 1'b1;
        @(negedge clk);
        #1;
        model_reset();
        rst_n           = 1'b1;
        tx.TX_TLP_VALID = 1'b0;
        check_outputs();
        step_model();

        run_cycles(1500, 40, 15);
        run_cycles(300, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
